lfsr_gen: RTL and testbench
===========================

Name: lfsr_gen

Overview:
Parametrised Fibonacci LFSR: generalised width, tap mask, seed load and a clock-enable step input instead of a private slow clock. Adds zero-seed lock-up protection and period measurement. It feeds pattern generators and scramblers in the lab designs. Observation-rate stepping comes from the shared clock-enable divider through `en`.

Parameters:
- WIDTH, 4, register width in bits (valid range 2..32).
- TAPS, 4'b0011, feedback tap mask, WIDTH bits.
  - feedback = XOR of state bits where TAPS=1.
  - TAPS[0] must be 1 for an invertible sequence.
- DEFAULT_SEED, 4'b0001, state after reset and the substitute for an all-zero seed. Must be non-zero.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- load  in  1  load `seed` this cycle
- seed  in  WIDTH  seed value, sampled when load=1
- en  in  1  advance one step this cycle
- state  out  WIDTH  current register contents
- bit_out  out  1  state[0], the bit shifted out next
- seed_err  out  1  one-cycle pulse: zero seed replaced
- wrap  out  1  one-cycle pulse: step returned state to reference seed
- period  out  WIDTH  last measured sequence length
- period_valid  out  1  period holds a completed measurement

Behaviour:
- Interface (already decided): one clock `clk`; reset `rst` is synchronous and active-high. All registers update on the rising edge of `clk` only.
- Reset values:
  - state = DEFAULT_SEED; ref_seed = DEFAULT_SEED; step_cnt = 0.
  - period = 0; period_valid = 0; wrap = 0; seed_err = 0.
- Priority per cycle is rst > load > en > hold.
- Step (en=1, load=0):
  - fb = ^(state & TAPS); state_next = {fb, state[WIDTH-1:1]}.
  - This is a right shift with feedback into the MSB, one step per enabled cycle.
- Hold (en=0, load=0): state, step_cnt, period and period_valid unchanged. wrap and seed_err are 0.
- Load (load=1):
  - If seed != 0: state <= seed and ref_seed <= seed.
  - If seed == 0: state <= DEFAULT_SEED, ref_seed <= DEFAULT_SEED, and seed_err=1 for the next cycle.
  - In both cases step_cnt <= 0 and period_valid <= 0; period keeps its old value.
  - en is ignored in a load cycle.
- Period measurement (step cycles only):
  - If state_next == ref_seed:
    - wrap=1 next cycle;
    - period <= step_cnt+1;
    - period_valid <= 1;
    - step_cnt <= 0.
  - Otherwise step_cnt <= step_cnt+1, saturating at all-ones. On saturation there is no wrap and period_valid keeps its value.
- Pulses: wrap and seed_err are registered, high for exactly one cycle, and 0 in every non-triggering cycle.
- All-zero state cannot be reached through load or reset. With TAPS[0]=0 the sequence may never return to the seed; step_cnt then saturates and period_valid stays 0.
- Reset mid-sequence: on the next edge, all outputs take their reset values. Pending pulses are cleared.
- Latency:
  - state is updated one cycle after load or en;
  - wrap and period are updated in the same edge as the wrapping step.

Optional Feature:
- Macro: LFSR_PERIOD_EN.
- Defined: step_cnt, ref_seed comparison, wrap, period and period_valid are built as described above.
- Undefined:
  - That logic is not synthesised.
  - Ports remain; wrap, period and period_valid are tied to 0.
  - state, bit_out and seed_err behaviour is identical to the defined case.

Test Plan:
1. Reset check: rst=1 for 2 cycles, then 0 with en=0 -> state=4'b0001, period_valid=0, wrap=0, seed_err=0, and the state holds.
2. Defaults, load seed 4'b1000, then en=1 continuously -> state follows this sequence:
   - 0100, 0010, 1001, 1100, 0110, 1011, 0101, 1010, 1101, 1110, 1111, 0111, 0011, 0001, 1000;
   - wrap pulses on the 15th step; period=15; period_valid=1.
3. load=1 with seed=0 -> state=4'b0001 next cycle, seed_err high for exactly 1 cycle, period_valid=0. Stepping 15 times then gives wrap and period=15.
4. Same cycle load=1 (seed=4'b1010) and en=1 -> state=1010, no shift. Next en gives 1101. load=0 with en toggling 1,0,1 advances exactly 2 steps.
5. rst asserted mid-run after 7 steps -> next cycle state=0001, step_cnt=0, period=0, period_valid=0. A following wrap occurs after exactly 15 steps.
6. Build without LFSR_PERIOD_EN, repeat scenario 2 -> identical state sequence; wrap, period and period_valid stay 0 throughout.

Source files
------------

// File: rtl/lfsr_gen.sv
// Parametrised Fibonacci LFSR with seed load, clock-enable stepping and zero-seed protection.
// Define LFSR_PERIOD_EN to build the period measurement (step_cnt, wrap, period, period_valid).
module lfsr_gen #(
  parameter int unsigned          WIDTH        = 4,
  parameter logic [WIDTH-1:0]     TAPS         = 4'b0011,
  parameter logic [WIDTH-1:0]     DEFAULT_SEED = 4'b0001
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] seed,
  input  logic             en,
  output logic [WIDTH-1:0] state,
  output logic             bit_out,
  output logic             seed_err,
  output logic             wrap,
  output logic [WIDTH-1:0] period,
  output logic             period_valid
);

  logic [WIDTH-1:0] state_q;
  logic [WIDTH-1:0] step_val;
  logic [WIDTH-1:0] load_val;
  logic             seed_zero;
  logic             fb;
  logic             seed_err_q;

  always_comb begin
    fb        = ^(state_q & TAPS);
    step_val  = {fb, state_q[WIDTH-1:1]};
    seed_zero = (seed == '0);
    load_val  = seed_zero ? DEFAULT_SEED : seed;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= DEFAULT_SEED;
      seed_err_q <= 1'b0;
    end else if (load) begin
      state_q    <= load_val;
      seed_err_q <= seed_zero;
    end else begin
      if (en) state_q <= step_val;
      seed_err_q <= 1'b0;
    end
  end

  assign state    = state_q;
  assign bit_out  = state_q[0];
  assign seed_err = seed_err_q;

`ifdef LFSR_PERIOD_EN
  logic [WIDTH-1:0] ref_seed;
  logic [WIDTH-1:0] step_cnt;
  logic [WIDTH-1:0] period_q;
  logic             period_valid_q;
  logic             wrap_q;
  logic             hit;
  logic             cnt_max;

  always_comb begin
    hit     = (step_val == ref_seed);
    cnt_max = &step_cnt;
  end

  // A saturated counter no longer represents a true length, so a late hit is ignored.
  always_ff @(posedge clk) begin
    if (rst) begin
      ref_seed       <= DEFAULT_SEED;
      step_cnt       <= '0;
      period_q       <= '0;
      period_valid_q <= 1'b0;
      wrap_q         <= 1'b0;
    end else if (load) begin
      ref_seed       <= load_val;
      step_cnt       <= '0;
      period_valid_q <= 1'b0;
      wrap_q         <= 1'b0;
    end else if (en) begin
      if (hit && !cnt_max) begin
        wrap_q         <= 1'b1;
        period_q       <= step_cnt + WIDTH'(1);
        period_valid_q <= 1'b1;
        step_cnt       <= '0;
      end else begin
        wrap_q <= 1'b0;
        if (!cnt_max) step_cnt <= step_cnt + WIDTH'(1);
      end
    end else begin
      wrap_q <= 1'b0;
    end
  end

  assign wrap         = wrap_q;
  assign period       = period_q;
  assign period_valid = period_valid_q;
`else
  assign wrap         = 1'b0;
  assign period       = '0;
  assign period_valid = 1'b0;
`endif

endmodule

// File: tb/tb_lfsr_gen.sv
// Scoreboard bench for lfsr_gen (WIDTH=4, TAPS=0011); period expectations follow LFSR_PERIOD_EN.
module tb_lfsr_gen;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       load = 1'b0;
  logic       en = 1'b0;
  logic [3:0] seed = 4'b0000;
  logic [3:0] state;
  logic       bit_out;
  logic       seed_err;
  logic       wrap;
  logic [3:0] period;
  logic       period_valid;

  int total = 0;
  int bad = 0;

  logic [11:0] exp_q[$];
  logic [11:0] e;

  // reference model
  logic [3:0] m_state = 4'b0001;
  logic [3:0] m_ref = 4'b0001;
  logic [3:0] m_cnt = 4'b0000;
  logic [3:0] m_period = 4'b0000;
  logic       m_pv = 1'b0;
  logic       m_wrap = 1'b0;
  logic       m_serr = 1'b0;

  always #5 clk = ~clk;

  lfsr_gen #(
    .WIDTH(4),
    .TAPS(4'b0011),
    .DEFAULT_SEED(4'b0001)
  ) dut (
    .clk(clk),
    .rst(rst),
    .load(load),
    .seed(seed),
    .en(en),
    .state(state),
    .bit_out(bit_out),
    .seed_err(seed_err),
    .wrap(wrap),
    .period(period),
    .period_valid(period_valid)
  );

  function automatic logic [11:0] obs();
    return {state, bit_out, seed_err, wrap, period, period_valid};
  endfunction

  task automatic drive(input logic r, input logic l, input logic en_i, input logic [3:0] s);
    logic [3:0] nxt;
    logic [11:0] x;
    @(negedge clk);
    rst = r; load = l; en = en_i; seed = s;
    if (r) begin
      m_state = 4'b0001; m_ref = 4'b0001; m_cnt = '0;
      m_period = '0; m_pv = 1'b0; m_wrap = 1'b0; m_serr = 1'b0;
    end else if (l) begin
      m_serr = (s == 4'b0000);
      m_state = m_serr ? 4'b0001 : s;
      m_ref = m_state; m_cnt = '0; m_pv = 1'b0; m_wrap = 1'b0;
    end else if (en_i) begin
      nxt = {m_state[0] ^ m_state[1], m_state[3:1]};
      m_serr = 1'b0;
      if (nxt == m_ref && m_cnt != 4'hF) begin
        m_wrap = 1'b1; m_period = m_cnt + 4'd1; m_pv = 1'b1; m_cnt = '0;
      end else begin
        m_wrap = 1'b0;
        if (m_cnt != 4'hF) m_cnt = m_cnt + 4'd1;
      end
      m_state = nxt;
    end else begin
      m_wrap = 1'b0; m_serr = 1'b0;
    end
`ifdef LFSR_PERIOD_EN
    x = {m_state, m_state[0], m_serr, m_wrap, m_period, m_pv};
`else
    x = {m_state, m_state[0], m_serr, 1'b0, 4'b0000, 1'b0};
`endif
    exp_q.push_back(x);
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 4; i++) begin
      drive(i < 2, 1'b0, 1'b0, 4'b0000);
      e = exp_q.pop_front();
      total++;
      if (obs() !== e) begin
        bad++;
        $display("FAIL reset[%0d] got=%h exp=%h", i, obs(), e);
      end
    end
    total++;
    if (state !== 4'b0001) begin
      bad++;
      $display("FAIL reset_state got=%b exp=0001", state);
    end
  endtask

  task automatic test_sequence();
    logic [3:0] seq [15];
    seq = '{4'b0100, 4'b0010, 4'b1001, 4'b1100, 4'b0110, 4'b1011, 4'b0101, 4'b1010,
            4'b1101, 4'b1110, 4'b1111, 4'b0111, 4'b0011, 4'b0001, 4'b1000};
    drive(1'b0, 1'b1, 1'b0, 4'b1000);
    e = exp_q.pop_front();
    total++;
    if (obs() !== e) begin
      bad++;
      $display("FAIL seq_load got=%h exp=%h", obs(), e);
    end
    for (int i = 0; i < 15; i++) begin
      drive(1'b0, 1'b0, 1'b1, 4'b0000);
      e = exp_q.pop_front();
      total++;
      if (obs() !== e) begin
        bad++;
        $display("FAIL seq_step[%0d] got=%h exp=%h", i, obs(), e);
      end
      total++;
      if (state !== seq[i]) begin
        bad++;
        $display("FAIL seq_table[%0d] got=%b exp=%b", i, state, seq[i]);
      end
    end
`ifdef LFSR_PERIOD_EN
    total++;
    if ({wrap, period, period_valid} !== {1'b1, 4'd15, 1'b1}) begin
      bad++;
      $display("FAIL seq_period got=%b/%0d/%b exp=1/15/1", wrap, period, period_valid);
    end
`else
    total++;
    if ({wrap, period, period_valid} !== 6'b0) begin
      bad++;
      $display("FAIL seq_noperiod got=%b/%0d/%b exp=0/0/0", wrap, period, period_valid);
    end
`endif
    drive(1'b0, 1'b0, 1'b0, 4'b0000);
    e = exp_q.pop_front();
    total++;
    if (obs() !== e) begin
      bad++;
      $display("FAIL seq_after got=%h exp=%h", obs(), e);
    end
  endtask

  task automatic test_zero_seed();
    drive(1'b0, 1'b1, 1'b0, 4'b0000);
    e = exp_q.pop_front();
    total++;
    if (obs() !== e || seed_err !== 1'b1 || state !== 4'b0001) begin
      bad++;
      $display("FAIL zero_seed got=%h exp=%h", obs(), e);
    end
    for (int i = 0; i < 16; i++) begin
      drive(1'b0, 1'b0, (i != 0), 4'b0000);
      e = exp_q.pop_front();
      total++;
      if (obs() !== e) begin
        bad++;
        $display("FAIL zero_step[%0d] got=%h exp=%h", i, obs(), e);
      end
    end
  endtask

  task automatic test_back_to_back();
    drive(1'b0, 1'b1, 1'b1, 4'b1010);
    e = exp_q.pop_front();
    total++;
    if (obs() !== e || state !== 4'b1010) begin
      bad++;
      $display("FAIL load_en got=%h exp=%h", obs(), e);
    end
    drive(1'b0, 1'b0, 1'b1, 4'b0000);
    e = exp_q.pop_front();
    total++;
    if (obs() !== e || state !== 4'b1101) begin
      bad++;
      $display("FAIL after_load got=%h exp=%h", obs(), e);
    end
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 1'b0, (i != 1), 4'b0000);
      e = exp_q.pop_front();
      total++;
      if (obs() !== e) begin
        bad++;
        $display("FAIL toggle[%0d] got=%h exp=%h", i, obs(), e);
      end
    end
    total++;
    if (state !== 4'b1111) begin
      bad++;
      $display("FAIL toggle_state got=%b exp=1111", state);
    end
  endtask

  task automatic test_mid_reset();
    int wrap_at;
    for (int i = 0; i < 7; i++) begin
      drive(1'b0, 1'b0, 1'b1, 4'b0000);
      e = exp_q.pop_front();
      total++;
      if (obs() !== e) begin
        bad++;
        $display("FAIL pre_rst[%0d] got=%h exp=%h", i, obs(), e);
      end
    end
    drive(1'b1, 1'b0, 1'b1, 4'b0000);
    e = exp_q.pop_front();
    total++;
    if (obs() !== e || obs() !== 12'b0001_1_0_0_0000_0) begin
      bad++;
      $display("FAIL mid_rst got=%h exp=%h", obs(), e);
    end
    wrap_at = -1;
    for (int i = 1; i <= 20; i++) begin
      drive(1'b0, 1'b0, 1'b1, 4'b0000);
      e = exp_q.pop_front();
      total++;
      if (obs() !== e) begin
        bad++;
        $display("FAIL post_rst[%0d] got=%h exp=%h", i, obs(), e);
      end
      if (wrap === 1'b1 && wrap_at < 0) wrap_at = i;
    end
    total++;
`ifdef LFSR_PERIOD_EN
    if (wrap_at != 15) begin
      bad++;
      $display("FAIL wrap_after_rst got=%0d exp=15", wrap_at);
    end
`else
    if (wrap_at != -1) begin
      bad++;
      $display("FAIL wrap_after_rst got=%0d exp=-1", wrap_at);
    end
`endif
  endtask

  initial begin
    test_reset();
    test_sequence();
    test_zero_seed();
    test_back_to_back();
    test_mid_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1);
  end
endmodule
